// File: rtl/sal_rw_turn_ctrl.sv
// -----------------------------------------------------------------------------
// sal_rw_turn_ctrl
//
// Read/write turnaround controller for a memory command scheduler. It decides
// whether the column-command bus currently serves reads or writes. It also
// inserts the read-to-write and write-to-read turnaround gaps between the
// two modes.
//
// Mode selection:
//   RD    : reads permitted. Switches towards writes when the write buffer is
//           high, when no reads are waiting, or when buffered writes have aged
//           out.
//   RD2WR : fixed-length gap of t_rtw_i+1 cycles, then WR.
//   WR    : writes permitted. Yields to waiting reads once the buffer has
//           drained to the low watermark or a full write burst has issued.
//   WR2RD : fixed-length gap of t_wtr_i+1 cycles, then RD.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   wr_cnt_i    complete write transactions buffered (5-bit unsigned)
//   rd_req_i    at least one read request pending
//   rd_issue_i  read column command issued this cycle
//   wr_issue_i  write column command issued this cycle
//   t_rtw_i     read-to-write turnaround cycles
//   t_wtr_i     write-to-read turnaround cycles
//   rd_en_o     read column commands permitted (state RD only)
//   wr_en_o     write column commands permitted (state WR only)
//   mode_o      current state: 0 RD, 1 RD2WR, 2 WR, 3 WR2RD
//   err_o       sticky flag: an issue happened while it was not permitted
// -----------------------------------------------------------------------------
module sal_rw_turn_ctrl #(
    parameter int HI_WM        = 6,
    parameter int LO_WM        = 2,
    parameter int WR_BURST_MAX = 8,
    parameter int AGE_MAX      = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] wr_cnt_i,
    input  logic       rd_req_i,
    input  logic       rd_issue_i,
    input  logic       wr_issue_i,
    input  logic [3:0] t_rtw_i,
    input  logic [3:0] t_wtr_i,
    output logic       rd_en_o,
    output logic       wr_en_o,
    output logic [1:0] mode_o,
    output logic       err_o
);

    // Parameter sanity: the watermarks must fit the 5-bit count and be ordered,
    // and the limits must fit their counters.
    generate
        if (!(LO_WM >= 0 && LO_WM < HI_WM && HI_WM <= 31)) begin : g_bad_wm
            $error("sal_rw_turn_ctrl: need 0 <= LO_WM < HI_WM <= 31");
        end
        if (!(WR_BURST_MAX >= 1 && WR_BURST_MAX <= 15)) begin : g_bad_burst
            $error("sal_rw_turn_ctrl: WR_BURST_MAX must be 1..15");
        end
        if (!(AGE_MAX >= 1 && AGE_MAX <= 128)) begin : g_bad_age
            $error("sal_rw_turn_ctrl: AGE_MAX must be 1..128");
        end
    endgenerate

    localparam logic [4:0] HI_WM_C   = 5'(HI_WM);
    localparam logic [4:0] LO_WM_C   = 5'(LO_WM);
    localparam logic [3:0] BURST_LIM = 4'(WR_BURST_MAX);
    localparam logic [6:0] AGE_LIM   = 7'(AGE_MAX - 1);

    typedef enum logic [1:0] {
        ST_RD    = 2'd0,
        ST_RD2WR = 2'd1,
        ST_WR    = 2'd2,
        ST_WR2RD = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [6:0] age_cnt;
    logic [3:0] burst_cnt;
    logic [3:0] turn_cnt;

    logic wr_pending;
    logic go_wr;
    logic go_rd;
    logic bad_issue;

    assign wr_pending = (wr_cnt_i != 5'd0);

    // Any one of these pulls read mode over to writes.
    assign go_wr = (wr_cnt_i >= HI_WM_C)
                || (!rd_req_i && wr_pending)
                || ((age_cnt == AGE_LIM) && wr_pending);

    // Write mode only yields when someone is actually waiting to read.
    assign go_rd = rd_req_i && ((wr_cnt_i <= LO_WM_C) || (burst_cnt >= BURST_LIM));

    // An issue is judged against the state it happened in, so an issue on the
    // cycle a transition is decided is still legal.
    assign bad_issue = (rd_issue_i && (state != ST_RD))
                    || (wr_issue_i && (state != ST_WR));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its peers; blocking here would create races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RD;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        rd_en_o   = 1'b0;
        wr_en_o   = 1'b0;
        unique case (state)
            ST_RD: begin
                rd_en_o = 1'b1;
                if (go_wr) state_nxt = ST_RD2WR;
            end
            ST_RD2WR: begin
                if (turn_cnt == 4'd0) state_nxt = ST_WR;
            end
            ST_WR: begin
                wr_en_o = 1'b1;
                if (go_rd) state_nxt = ST_WR2RD;
            end
            ST_WR2RD: begin
                if (turn_cnt == 4'd0) state_nxt = ST_RD;
            end
            default: state_nxt = ST_RD;
        endcase
    end

    assign mode_o = state;

    // Turnaround length is captured on entry, so later changes of the timing
    // inputs cannot stretch or shorten a gap already in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            turn_cnt <= 4'd0;
        end else if (state == ST_RD && state_nxt == ST_RD2WR) begin
            turn_cnt <= t_rtw_i;
        end else if (state == ST_WR && state_nxt == ST_WR2RD) begin
            turn_cnt <= t_wtr_i;
        end else if ((state == ST_RD2WR || state == ST_WR2RD) && turn_cnt != 4'd0) begin
            turn_cnt <= turn_cnt - 4'd1;
        end
    end

    // Age of buffered writes while reads are being served.
    always_ff @(posedge clk) begin
        if (rst) begin
            age_cnt <= 7'd0;
        end else if (state != ST_RD || state_nxt != ST_RD || !wr_pending) begin
            age_cnt <= 7'd0;
        end else if (age_cnt < AGE_LIM) begin
            age_cnt <= age_cnt + 7'd1;
        end
    end

    // Writes issued in the current write mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= 4'd0;
        end else if (state != ST_WR && state_nxt == ST_WR) begin
            burst_cnt <= 4'd0;
        end else if (state == ST_WR && wr_issue_i && burst_cnt < BURST_LIM) begin
            burst_cnt <= burst_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (bad_issue) begin
            err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sal_rw_turn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sal_rw_turn_ctrl
//
// Directed scenarios for the mode-switch rules, followed by a long randomized
// run compared cycle by cycle against a behavioural model of the controller.
// -----------------------------------------------------------------------------
module tb_sal_rw_turn_ctrl;

    localparam int HI_WM        = 6;
    localparam int LO_WM        = 2;
    localparam int WR_BURST_MAX = 8;
    localparam int AGE_MAX      = 64;

    logic       clk;
    logic       rst;
    logic [4:0] wr_cnt;
    logic       rd_req;
    logic       rd_issue;
    logic       wr_issue;
    logic [3:0] t_rtw;
    logic [3:0] t_wtr;
    logic       rd_en;
    logic       wr_en;
    logic [1:0] mode;
    logic       err;

    int vectors;
    int miscompares;

    // Behavioural model: mode as an int, turnaround as cycles left to spend.
    int m_mode;
    int m_age;
    int m_burst;
    int m_left;
    bit m_err;

    sal_rw_turn_ctrl #(
        .HI_WM        (HI_WM),
        .LO_WM        (LO_WM),
        .WR_BURST_MAX (WR_BURST_MAX),
        .AGE_MAX      (AGE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_cnt_i   (wr_cnt),
        .rd_req_i   (rd_req),
        .rd_issue_i (rd_issue),
        .wr_issue_i (wr_issue),
        .t_rtw_i    (t_rtw),
        .t_wtr_i    (t_wtr),
        .rd_en_o    (rd_en),
        .wr_en_o    (wr_en),
        .mode_o     (mode),
        .err_o      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog expired");
    end

    // One clock: inputs were set after the previous edge, outputs are read 1 time unit after this one.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_cnt   = 5'd0;
        rd_req   = 1'b1;
        rd_issue = 1'b0;
        wr_issue = 1'b0;
        t_rtw    = 4'd0;
        t_wtr    = 4'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // Model update for one rising edge, using the inputs the DUT samples.
    task automatic model_clock();
        bit wr_nz;
        if (rst) begin
            m_mode  = 0;
            m_age   = 0;
            m_burst = 0;
            m_left  = 0;
            m_err   = 1'b0;
            return;
        end
        if ((rd_issue && m_mode != 0) || (wr_issue && m_mode != 2)) m_err = 1'b1;
        wr_nz = (wr_cnt != 0);
        case (m_mode)
            0: begin
                if (int'(wr_cnt) >= HI_WM || (!rd_req && wr_nz) || (m_age == AGE_MAX - 1 && wr_nz)) begin
                    m_mode = 1;
                    m_left = int'(t_rtw) + 1;
                    m_age  = 0;
                end else if (!wr_nz) begin
                    m_age = 0;
                end else if (m_age < AGE_MAX - 1) begin
                    m_age = m_age + 1;
                end
            end
            1: begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_mode  = 2;
                    m_burst = 0;
                end
            end
            2: begin
                if (rd_req && (int'(wr_cnt) <= LO_WM || m_burst >= WR_BURST_MAX)) begin
                    m_mode = 3;
                    m_left = int'(t_wtr) + 1;
                end else if (wr_issue && m_burst < WR_BURST_MAX) begin
                    m_burst = m_burst + 1;
                end
            end
            default: begin
                m_left = m_left - 1;
                if (m_left == 0) m_mode = 0;
            end
        endcase
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        wr_cnt   = 5'd31;
        rd_req   = 1'b0;
        rd_issue = 1'b1;
        wr_issue = 1'b1;
        t_rtw    = 4'd7;
        t_wtr    = 4'd7;
        for (int i = 0; i < 3; i++) begin
            cyc();
            vectors++;
            if (mode !== 2'd0 || rd_en !== 1'b1 || wr_en !== 1'b0 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state cyc%0d: mode=%0d rd_en=%b wr_en=%b err=%b, expected mode=0 rd_en=1 wr_en=0 err=0",
                         i, mode, rd_en, wr_en, err);
            end
        end
        rst = 1'b0;
        idle_inputs();
        cyc();
        vectors++;
        if (mode !== 2'd0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: mode=%0d err=%b, expected mode=0 err=0", mode, err);
        end
    endtask

    // High watermark forces RD2WR; the gap keeps its length despite input changes.
    task automatic test_rtw_turn();
        do_reset();
        t_rtw = 4'd3;
        cyc();
        wr_cnt = 5'd6;
        for (int i = 0; i < 4; i++) begin
            cyc();
            vectors++;
            if (mode !== 2'd1 || rd_en !== 1'b0 || wr_en !== 1'b0) begin
                miscompares++;
                $display("FAIL rtw_gap cyc%0d: mode=%0d rd_en=%b wr_en=%b, expected mode=1 rd_en=0 wr_en=0",
                         i, mode, rd_en, wr_en);
            end
            if (i == 0) begin
                t_rtw  = 4'd0;
                wr_cnt = 5'd0;
                rd_req = 1'b0;
            end
        end
        cyc();
        vectors++;
        if (mode !== 2'd2 || wr_en !== 1'b1 || rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rtw_enter_wr: mode=%0d wr_en=%b rd_en=%b, expected mode=2 wr_en=1 rd_en=0",
                     mode, wr_en, rd_en);
        end
    endtask

    // Continues in WR from test_rtw_turn: a full burst yields to reads.
    task automatic test_burst();
        rd_req   = 1'b1;
        wr_cnt   = 5'd10;
        t_wtr    = 4'd0;
        wr_issue = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            vectors++;
            if (mode !== 2'd2) begin
                miscompares++;
                $display("FAIL burst_hold issue%0d: mode=%0d, expected 2", i + 1, mode);
            end
        end
        wr_issue = 1'b0;
        cyc();
        vectors++;
        if (mode !== 2'd3) begin
            miscompares++;
            $display("FAIL burst_yield: mode=%0d, expected 3", mode);
        end
        cyc();
        vectors++;
        if (mode !== 2'd0 || rd_en !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL wtr_zero_gap: mode=%0d rd_en=%b err=%b, expected mode=0 rd_en=1 err=0",
                     mode, rd_en, err);
        end
    endtask

    // A single aged write forces the switch after 64 RD cycles.
    task automatic test_age();
        do_reset();
        cyc();
        wr_cnt = 5'd1;
        for (int i = 1; i < 64; i++) begin
            cyc();
            vectors++;
            if (mode !== 2'd0) begin
                miscompares++;
                $display("FAIL age_hold cyc%0d: mode=%0d, expected 0", i, mode);
            end
        end
        cyc();
        vectors++;
        if (mode !== 2'd1) begin
            miscompares++;
            $display("FAIL age_force: mode=%0d, expected 1", mode);
        end
    endtask

    // WR with nothing to do and no reads waiting stays put.
    task automatic test_wr_hold();
        do_reset();
        rd_req = 1'b0;
        wr_cnt = 5'd1;
        cyc();
        vectors++;
        if (mode !== 2'd1) begin
            miscompares++;
            $display("FAIL idle_rd_to_rtw: mode=%0d, expected 1", mode);
        end
        wr_cnt = 5'd0;
        cyc();
        vectors++;
        if (mode !== 2'd2) begin
            miscompares++;
            $display("FAIL idle_enter_wr: mode=%0d, expected 2", mode);
        end
        for (int i = 0; i < 100; i++) begin
            cyc();
            vectors++;
            if (mode !== 2'd2) begin
                miscompares++;
                $display("FAIL wr_hold cyc%0d: mode=%0d, expected 2", i, mode);
            end
        end
        t_wtr  = 4'd2;
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            vectors++;
            if (mode !== 2'd3) begin
                miscompares++;
                $display("FAIL wtr_gap cyc%0d: mode=%0d, expected 3", i, mode);
            end
        end
        cyc();
        vectors++;
        if (mode !== 2'd0) begin
            miscompares++;
            $display("FAIL wtr_to_rd: mode=%0d, expected 0", mode);
        end
    endtask

    // Sticky error flag, and reset in the middle of a turnaround.
    task automatic test_err_reset();
        do_reset();
        wr_issue = 1'b1;
        cyc();
        wr_issue = 1'b0;
        vectors++;
        if (err !== 1'b1 || mode !== 2'd0) begin
            miscompares++;
            $display("FAIL err_set: err=%b mode=%0d, expected err=1 mode=0", err, mode);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            vectors++;
            if (err !== 1'b1) begin
                miscompares++;
                $display("FAIL err_sticky cyc%0d: err=%b, expected 1", i, err);
            end
        end
        wr_cnt = 5'd6;
        t_rtw  = 4'd5;
        cyc();
        cyc();
        vectors++;
        if (mode !== 2'd1) begin
            miscompares++;
            $display("FAIL err_mid_rtw: mode=%0d, expected 1", mode);
        end
        rst    = 1'b1;
        wr_cnt = 5'd0;
        cyc();
        rst = 1'b0;
        vectors++;
        if (mode !== 2'd0 || rd_en !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_rtw: mode=%0d rd_en=%b err=%b, expected mode=0 rd_en=1 err=0",
                     mode, rd_en, err);
        end
        rd_issue = 1'b1;
        cyc();
        rd_issue = 1'b0;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL legal_rd_issue: err=%b, expected 0", err);
        end
        // A fresh turnaround must use the new t_rtw, with nothing left over from before reset.
        wr_cnt = 5'd6;
        t_rtw  = 4'd1;
        cyc();
        cyc();
        vectors++;
        if (mode !== 2'd1) begin
            miscompares++;
            $display("FAIL fresh_rtw_gap: mode=%0d, expected 1", mode);
        end
        cyc();
        vectors++;
        if (mode !== 2'd2) begin
            miscompares++;
            $display("FAIL fresh_rtw_end: mode=%0d, expected 2", mode);
        end
    endtask

    task automatic test_random();
        int r;
        bit read_heavy;
        do_reset();
        m_mode  = 0;
        m_age   = 0;
        m_burst = 0;
        m_left  = 0;
        m_err   = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            read_heavy = ((i / 300) % 2) == 1;
            rst = ($urandom_range(0, 249) == 0);
            if (read_heavy) begin
                rd_req = 1'b1;
                wr_cnt = 5'($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 4));
            end else begin
                rd_req = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 9);
                if (r < 3)      wr_cnt = 5'd0;
                else if (r < 8) wr_cnt = 5'($urandom_range(1, 7));
                else            wr_cnt = 5'($urandom_range(8, 31));
            end
            t_rtw    = 4'($urandom_range(0, 7) == 0 ? $urandom_range(5, 15) : $urandom_range(0, 4));
            t_wtr    = 4'($urandom_range(0, 7) == 0 ? $urandom_range(5, 15) : $urandom_range(0, 4));
            rd_issue = (m_mode == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 599) == 0);
            wr_issue = (m_mode == 2) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 599) == 0);
            @(posedge clk);
            model_clock();
            #1;
            vectors++;
            if (mode !== 2'(m_mode) || rd_en !== (m_mode == 0) || wr_en !== (m_mode == 2) || err !== m_err) begin
                miscompares++;
                $display("FAIL random cyc%0d: mode=%0d rd_en=%b wr_en=%b err=%b, expected mode=%0d rd_en=%b wr_en=%b err=%b",
                         i, mode, rd_en, wr_en, err, m_mode, (m_mode == 0), (m_mode == 2), m_err);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        idle_inputs();
        test_reset();
        test_rtw_turn();
        test_burst();
        test_age();
        test_wr_hold();
        test_err_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
